// File: rtl/reset_seq_ctrl.sv
// Power-on reset sequencer: releases NUM_STAGES reset domains in order, each after a hold
// delay and an optional ack with timeout, plus done/fail status and a heartbeat LED.
module reset_seq_ctrl #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned STAGE_DELAY = 10_000_000,
  parameter int unsigned TIMEOUT = 100_000_000,
  parameter int unsigned HB_PERIOD = 100_000_000,
  parameter logic [NUM_STAGES-1:0] ACK_MASK = '0,
  localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk0,
  input  logic                  reset_in,
  input  logic                  sw_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  seq_done,
  output logic                  seq_fail,
  output logic [IDX_W-1:0]      fail_stage,
  output logic                  heartbeat
);

  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

  if (NUM_STAGES < 1 || HB_PERIOD < 4 || STAGE_DELAY < 1 || TIMEOUT < 1 ||
      STAGE_DELAY > CNT_SPAN || TIMEOUT > CNT_SPAN || HB_PERIOD > CNT_SPAN) begin : g_param_check
    $error("reset_seq_ctrl: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HB_LAST      = CNT_W'(HB_PERIOD - 1);
  localparam logic [CNT_W-1:0] HB_FAST_LAST = CNT_W'(HB_PERIOD / 4 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {ST_DELAY, ST_ACK, ST_RUN, ST_FAIL} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [NUM_STAGES-1:0]   stage_reset_nxt;
  logic                    seq_done_nxt, seq_fail_nxt;
  logic [IDX_W-1:0]        fail_stage_nxt;

  always_comb begin
    // NOTE: every next-value signal starts from its held value so no path leaves it unassigned (no latch).
    state_nxt       = state;
    idx_nxt         = idx;
    cnt_nxt         = cnt;
    stage_reset_nxt = stage_reset;
    seq_done_nxt    = seq_done;
    seq_fail_nxt    = seq_fail;
    fail_stage_nxt  = fail_stage;

    unique case (state)
      ST_DELAY: begin
        if (cnt == DELAY_LAST) begin
          stage_reset_nxt[idx] = 1'b0;
          cnt_nxt              = '0;
          state_nxt            = ST_ACK;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_ACK: begin
        // The ack is tested before the timeout so an ack on the last cycle still wins.
        if (!ACK_MASK[idx] || stage_ack[idx]) begin
          if (idx == LAST_IDX) begin
            seq_done_nxt = 1'b1;
            state_nxt    = ST_RUN;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            cnt_nxt   = '0;
            state_nxt = ST_DELAY;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          seq_fail_nxt   = 1'b1;
          fail_stage_nxt = idx;
          state_nxt      = ST_FAIL;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RUN, ST_FAIL: ;
    endcase

    if (sw_reset_req) begin
      state_nxt       = ST_DELAY;
      idx_nxt         = '0;
      cnt_nxt         = '0;
      stage_reset_nxt = '1;
      seq_done_nxt    = 1'b0;
      seq_fail_nxt    = 1'b0;
      fail_stage_nxt  = '0;
    end
  end

  always_ff @(posedge clk0) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    if (!reset_in) begin
      state       <= ST_DELAY;
      idx         <= '0;
      cnt         <= '0;
      stage_reset <= '1;
      seq_done    <= 1'b0;
      seq_fail    <= 1'b0;
      fail_stage  <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      stage_reset <= stage_reset_nxt;
      seq_done    <= seq_done_nxt;
      seq_fail    <= seq_fail_nxt;
      fail_stage  <= fail_stage_nxt;
    end
  end

  logic [CNT_W-1:0] hb_cnt;
  logic [CNT_W-1:0] hb_last;

  assign hb_last = seq_fail ? HB_FAST_LAST : HB_LAST;

  // A count already past a freshly shortened limit restarts silently instead of wrapping.
  always_ff @(posedge clk0) begin
    if (!reset_in) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else if (hb_cnt >= hb_last) begin
      hb_cnt <= '0;
      if (hb_cnt == hb_last) heartbeat <= ~heartbeat;
    end else begin
      hb_cnt <= hb_cnt + CNT_W'(1);
    end
  end

endmodule
